// File: rtl/rr_mux_stage_pkg.sv
// Shared definitions for the N:1 arbitrated mux stage: arbitration mode
// encodings, default data width and a small index helper.
package rr_mux_stage_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;
  localparam int DEF_WIDTH = 16;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way arbiter: round-robin from an owned pointer, or fixed lowest-index
// priority. Produces a one-hot grant and its binary index.
module rr_arbiter
  import rr_mux_stage_pkg::*;
#(
  parameter int N    = 2,
  parameter int MODE = ARB_RR,
  localparam int SW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] idx;
  logic          found;
  int            sum;

  // Search starts at ptr and wraps; in fixed mode ptr stays 0, so the same
  // search degenerates to lowest-index-wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    sum       = 0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr) + k;
      if (sum >= N) sum = sum - N;
      idx = SW'(sum);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (MODE == ARB_RR && advance)
      ptr <= SW'(wrap_inc(int'(grant_idx), N));
  end

endmodule

// File: rtl/rr_mux_stage.sv
// N:1 valid/ready mux with built-in arbitration and a registered output
// slot; accepts a new beat whenever the slot is empty or being drained.
module rr_mux_stage
  import rr_mux_stage_pkg::*;
#(
  parameter int N     = 2,
  parameter int WIDTH = DEF_WIDTH,
  parameter int MODE  = ARB_RR,
  localparam int SW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_src,
  input  logic               out_ready
);

  logic [N-1:0]     grant;
  logic [SW-1:0]    grant_idx;
  logic             free;
  logic             transfer;
  logic [WIDTH-1:0] mux_data;

  assign free     = !out_valid || out_ready;
  assign in_ready = (free && !reset) ? grant : '0;
  assign transfer = |in_ready;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++)
      mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
  end

  // Pop and reload in the same cycle simply reloads; no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_src   <= grant_idx;
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_stage.sv
// Scoreboard bench for rr_mux_stage: one round-robin and one fixed-priority
// instance, directed stimulus with hand-computed expected beats.
module tb_rr_mux_stage;
  import rr_mux_stage_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_rr, reset_fx;
  logic [N-1:0]   valid_rr, valid_fx, ready_rr, ready_fx;
  logic [N*W-1:0] data_rr, data_fx;
  logic           ovalid_rr, ovalid_fx, oready_rr, oready_fx;
  logic [W-1:0]   odata_rr, odata_fx;
  logic [1:0]     osrc_rr, osrc_fx;

  rr_mux_stage #(.N(N), .WIDTH(W), .MODE(ARB_RR)) dut_rr (
    .clk(clk), .reset(reset_rr), .in_valid(valid_rr), .in_data(data_rr),
    .in_ready(ready_rr), .out_valid(ovalid_rr), .out_data(odata_rr),
    .out_src(osrc_rr), .out_ready(oready_rr)
  );

  rr_mux_stage #(.N(N), .WIDTH(W), .MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .reset(reset_fx), .in_valid(valid_fx), .in_data(data_fx),
    .in_ready(ready_fx), .out_valid(ovalid_fx), .out_data(odata_fx),
    .out_src(osrc_fx), .out_ready(oready_fx)
  );

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   src;
  } beat_t;

  beat_t q_rr[$];
  beat_t q_fx[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_rr(input int src, input logic [W-1:0] base);
    beat_t b;
    b.data = base + W'(src);
    b.src  = 2'(src);
    q_rr.push_back(b);
  endtask

  task automatic push_fx(input int src);
    beat_t b;
    b.data = 16'hB000 + W'(src);
    b.src  = 2'(src);
    q_fx.push_back(b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon_rr
    beat_t b;
    if (ovalid_rr && oready_rr) begin
      if (q_rr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rr_unexpected_beat: got src %0d data %0h, expected no beat", osrc_rr, odata_rr);
      end else begin
        b = q_rr.pop_front();
        check("rr_data", 32'(odata_rr), 32'(b.data));
        check("rr_src", 32'(osrc_rr), 32'(b.src));
      end
    end
  end

  always @(negedge clk) begin : mon_fx
    beat_t b;
    if (ovalid_fx && oready_fx) begin
      if (q_fx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fx_unexpected_beat: got src %0d data %0h, expected no beat", osrc_fx, odata_fx);
      end else begin
        b = q_fx.pop_front();
        check("fx_data", 32'(odata_fx), 32'(b.data));
        check("fx_src", 32'(osrc_fx), 32'(b.src));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset_rr  = 1'b1;
    reset_fx  = 1'b1;
    valid_rr  = '1;
    valid_fx  = 4'b0101;
    oready_rr = 1'b1;
    oready_fx = 1'b1;
    for (int i = 0; i < N; i++) begin
      data_rr[i*W +: W] = 16'hA000 + W'(i);
      data_fx[i*W +: W] = 16'hB000 + W'(i);
    end

    // Reset with all requests pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rr_reset_out_valid", 32'(ovalid_rr), 0);
    check("rr_reset_in_ready", 32'(ready_rr), 0);
    check("rr_reset_out_data", 32'(odata_rr), 0);
    check("rr_reset_out_src", 32'(osrc_rr), 0);
    check("fx_reset_in_ready", 32'(ready_fx), 0);

    // Round-robin fairness, one beat per cycle
    for (int k = 0; k < 8; k++) push_rr(k % 4, 16'hA000);
    step();
    reset_rr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_fair_grant", 32'(ready_rr), 32'(1 << (k % 4)));
      if (k > 0) check("rr_fair_no_bubble", 32'(ovalid_rr), 1);
      step();
    end
    valid_rr = '0;
    @(negedge clk);
    check("rr_fair_last_valid", 32'(ovalid_rr), 1);
    step();

    // Backpressure: hold ch0 beat for 3 cycles
    oready_rr = 1'b0;
    valid_rr  = '1;
    push_rr(0, 16'hA000);
    @(negedge clk);
    check("rr_bp_first_grant", 32'(ready_rr), 1);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rr_bp_hold_valid", 32'(ovalid_rr), 1);
      check("rr_bp_hold_data", 32'(odata_rr), 32'h0000A000);
      check("rr_bp_hold_src", 32'(osrc_rr), 0);
      check("rr_bp_in_ready", 32'(ready_rr), 0);
      step();
    end
    oready_rr = 1'b1;
    push_rr(1, 16'hA000);
    @(negedge clk);
    check("rr_bp_release_grant", 32'(ready_rr), 32'b0010);
    step();
    valid_rr = '0;
    @(negedge clk);
    check("rr_bp_no_bubble_valid", 32'(ovalid_rr), 1);
    check("rr_bp_no_bubble_src", 32'(osrc_rr), 1);
    step();

    // Wrap and skip: pointer to 3, only ch1 requests
    valid_rr = 4'b0100;
    push_rr(2, 16'hA000);
    @(negedge clk);
    check("rr_wrap_setup_grant", 32'(ready_rr), 32'b0100);
    step();
    valid_rr = 4'b0010;
    data_rr[3*W +: W] = 16'hBEEF;
    push_rr(1, 16'hA000);
    @(negedge clk);
    check("rr_wrap_skip_grant", 32'(ready_rr), 32'b0010);
    step();
    valid_rr = '1;
    data_rr[3*W +: W] = 16'hA003;
    push_rr(2, 16'hA000);
    @(negedge clk);
    check("rr_ptr_after_wrap", 32'(ready_rr), 32'b0100);
    step();
    valid_rr = '0;
    step();

    // Reset mid-operation with a held beat
    oready_rr = 1'b0;
    valid_rr  = '1;
    @(negedge clk);
    check("rr_mid_grant", 32'(ready_rr), 32'b1000);
    step();
    reset_rr = 1'b1;
    @(negedge clk);
    check("rr_mid_held_valid", 32'(ovalid_rr), 1);
    check("rr_mid_reset_in_ready", 32'(ready_rr), 0);
    step();
    reset_rr  = 1'b0;
    oready_rr = 1'b1;
    for (int k = 0; k < 4; k++) push_rr(k, 16'hA000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) check("rr_post_reset_valid", 32'(ovalid_rr), 0);
      check("rr_post_reset_grant", 32'(ready_rr), 32'(1 << k));
      step();
    end
    valid_rr = '0;
    repeat (3) step();

    // Fixed priority: ch0 and ch2 requesting, then ch0 drops
    reset_fx = 1'b0;
    for (int k = 0; k < 3; k++) push_fx(0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("fx_prio_grant", 32'(ready_fx), 32'b0001);
      step();
    end
    valid_fx = 4'b0100;
    push_fx(2);
    @(negedge clk);
    check("fx_drop_grant", 32'(ready_fx), 32'b0100);
    step();
    valid_fx = '0;
    repeat (3) step();

    check("rr_scoreboard_drained", 32'(q_rr.size()), 0);
    check("fx_scoreboard_drained", 32'(q_fx.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
